// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run-control and self-check monitor for CPU simulation / FPGA bring-up.
// Holds the CPU in reset for RST_HOLD_CYCLES edges after rst falls, then counts RUN
// cycles. It snoops the CPU data-memory write port for a tohost completion write
// (odd value at TOHOST_ADDR) and reports pass/fail/timeout as sticky flags.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   cpu_rst_o       reset driven to the CPU (registered)
//   mem_we/addr/wdata  snooped CPU data-memory write port
//   running         high while in RUN
//   done            sticky: finished by any cause
//   pass/fail/timeout  sticky result; exactly one is set when done=1
//   test_code       mem_wdata>>1 captured on fail, else 0
//   cycle_count     RUN cycles elapsed (saturating)
//
// Optional: define SIM_FINISH_EN (simulation only) to print the result when done
// rises and call $finish one clock later.
`timescale 1ns/1ps
module sim_run_ctrl #(
  parameter int unsigned       RST_HOLD_CYCLES = 2,
  parameter int unsigned       TIMEOUT_CYCLES  = 150,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       COUNT_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 32'h0000_1000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               cpu_rst_o,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic               running,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [DATA_W-1:0]  test_code,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TO_LAST   = COUNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  state_t             state_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic               cpu_rst_q;
  logic               running_q;
  logic               done_q;
  logic               pass_q;
  logic               fail_q;
  logic               timeout_q;
  logic [DATA_W-1:0]  test_code_q;
  logic [COUNT_W-1:0] cycle_count_q;

  logic               cmpl_hit;
  logic               pass_hit;
  logic               to_hit;
  logic [COUNT_W-1:0] cycle_count_d;

  always_comb begin
    cmpl_hit      = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    pass_hit      = (mem_wdata == DATA_W'(1));
    // Completion write in the same cycle takes priority over the timeout.
    to_hit        = (TIMEOUT_CYCLES != 0) && (cycle_count_q == TO_LAST) && !cmpl_hit;
    cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HOLD;
      hold_cnt_q    <= '0;
      cpu_rst_q     <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      test_code_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q   <= RUN;
            cpu_rst_q <= 1'b0;
            running_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          cycle_count_q <= cycle_count_d;
          if (cmpl_hit) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            if (pass_hit) begin
              pass_q <= 1'b1;
            end else begin
              fail_q      <= 1'b1;
              test_code_q <= mem_wdata >> 1;
            end
          end else if (to_hit) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        DONE: begin
          // Everything frozen until rst.
        end
        default: state_q <= HOLD;
      endcase
    end
  end

`ifdef SIM_FINISH_EN
  logic sim_fin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sim_fin_q <= 1'b0;
    end else begin
      if (sim_fin_q) $finish;
      if (state_q == RUN && (cmpl_hit || to_hit)) begin
        sim_fin_q <= 1'b1;
        if (cmpl_hit && pass_hit)
          $display("PASS cycles=%0d", cycle_count_d);
        else if (cmpl_hit)
          $display("FAIL code=%0d cycles=%0d", mem_wdata >> 1, cycle_count_d);
        else
          $display("TIMEOUT cycles=%0d", cycle_count_d);
      end
    end
  end
`endif

  assign cpu_rst_o   = cpu_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign test_code   = test_code_q;
  assign cycle_count = cycle_count_q;

endmodule
